// File: rtl/tim_reload_sched.sv
// Round-robin reload scheduler for the dual-channel APB timer: each grant
// drives a disable / load / enable write sequence to the granted channel.
module tim_reload_sched #(
  parameter logic [31:0] TIM_BASE  = 32'h0000_0000,
  parameter logic [31:0] CH_STRIDE = 32'h14,
  parameter logic [31:0] CTRL_ON   = 32'h3,
  parameter logic [31:0] CTRL_OFF  = 32'h2
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [1:0]  req,
  input  logic [31:0] req_load0,
  input  logic [31:0] req_load1,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata
);

  typedef enum logic [2:0] {
    IDLE, DIS_S, DIS_A, LD_S, LD_A, EN_S, EN_A, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [31:0]       load_q, load_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic [1:0][31:0]  req_load;
  logic [31:0]       chb_d;

  assign req_load = {req_load1, req_load0};

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      load_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      load_q   <= load_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    load_d  = load_q;
    case (state_q)
      IDLE: if (req != 2'b00) begin
        // Both requesting: the channel not served last time wins.
        gnt_d   = (req == 2'b11) ? ~last_q : req[1];
        last_d  = gnt_d;
        load_d  = req_load[gnt_d];
        state_d = DIS_S;
      end
      DIS_S:   state_d = DIS_A;
      DIS_A:   state_d = LD_S;
      LD_S:    state_d = LD_A;
      LD_A:    state_d = EN_S;
      EN_S:    state_d = EN_A;
      EN_A:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data are computed for the upcoming state so the registers hold
  // a stable value across both cycles of each S/A pair.
  always_comb begin
    chb_d    = TIM_BASE + (gnt_d ? CH_STRIDE : 32'd0);
    paddr_d  = '0;
    pwdata_d = '0;
    case (state_d)
      DIS_S, DIS_A: begin paddr_d = chb_d + 32'd8; pwdata_d = CTRL_OFF; end
      LD_S,  LD_A:  begin paddr_d = chb_d;         pwdata_d = load_d;   end
      EN_S,  EN_A:  begin paddr_d = chb_d + 32'd8; pwdata_d = CTRL_ON;  end
      default:      begin paddr_d = '0;            pwdata_d = '0;       end
    endcase
  end

  assign m_psel    = (state_q != IDLE) && (state_q != DONE);
  assign m_penable = (state_q == DIS_A) || (state_q == LD_A) || (state_q == EN_A);
  assign m_pwrite  = m_psel;
  assign m_paddr   = paddr_q;
  assign m_pwdata  = pwdata_q;
  assign busy      = (state_q != IDLE);
  assign ack       = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_tim_reload_sched.sv
// Randomized bench for tim_reload_sched against a cycle-count transaction model,
// plus directed scenarios with literal expected write sequences.
module tb_tim_reload_sched;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'h14;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] req_load0 = '0, req_load1 = '0;
  logic [1:0]  ack;
  logic        busy, m_psel, m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;

  tim_reload_sched dut (
    .pclk(pclk), .preset(preset), .req(req), .req_load0(req_load0),
    .req_load1(req_load1), .ack(ack), .busy(busy), .m_psel(m_psel),
    .m_penable(m_penable), .m_pwrite(m_pwrite), .m_paddr(m_paddr),
    .m_pwdata(m_pwdata)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: a grant occupies 8 edges; phase = edges since grant.
  int          rem = 0;
  logic        gnt_m = 1'b0, last_m = 1'b1;
  logic [31:0] load_m = '0;
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      rem = 0; gnt_m = 1'b0; last_m = 1'b1; load_m = '0;
    end else begin
      if (rem > 0) rem--;
      if (rem == 0 && req != 2'b00) begin
        gnt_m  = (req == 2'b11) ? ~last_m : req[1];
        last_m = gnt_m;
        load_m = gnt_m ? req_load1 : req_load0;
        rem    = 8;
      end
    end
  end

  int tcyc = 0;
  always @(posedge pclk) tcyc++;

  logic [1:0]  ack_seen = 2'b00;
  logic [31:0] wa[$], wd[$];
  logic [1:0]  acks[$];
  int          ackt[$];

  always @(negedge pclk) begin : monitor
    int ph; logic act, wr; logic [31:0] cb, ea, ed; logic [1:0] eack;
    ph  = 8 - rem;
    act = (rem > 0);
    wr  = act && ph < 6;
    cb  = BASE + (gnt_m ? STRIDE : 32'd0);
    ea  = !wr ? 32'd0 : (ph / 2 == 1) ? cb : cb + 32'd8;
    ed  = !wr ? 32'd0 : (ph / 2 == 0) ? 32'd2 : (ph / 2 == 1) ? load_m : 32'd3;
    eack = (act && ph == 6) ? (gnt_m ? 2'b10 : 2'b01) : 2'b00;
    chk("psel",    32'(m_psel),    32'(wr));
    chk("penable", 32'(m_penable), 32'(wr && ph[0]));
    chk("pwrite",  32'(m_pwrite),  32'(wr));
    chk("paddr",   m_paddr,        ea);
    chk("pwdata",  m_pwdata,       ed);
    chk("busy",    32'(busy),      32'(act && ph < 7));
    chk("ack",     32'(ack),       32'(eack));
    ack_seen = ack;
    if (m_psel && m_penable) begin wa.push_back(m_paddr); wd.push_back(m_pwdata); end
    if (ack != 2'b00) begin acks.push_back(ack); ackt.push_back(tcyc); end
  end

  logic auto_drop = 1'b1;
  task automatic cyc();
    @(posedge pclk); #1;
    if (auto_drop) req = req & ~ack_seen;
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); acks.delete(); ackt.delete();
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, (i < wa.size()) ? wa[i] : 32'hXXXX_XXXX, a);
    chk({tag, "_data"}, (i < wd.size()) ? wd[i] : 32'hXXXX_XXXX, d);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_psel"},    32'(m_psel),    32'd0);
    chk({tag, "_penable"}, 32'(m_penable), 32'd0);
    chk({tag, "_paddr"},   m_paddr,        32'd0);
    chk({tag, "_pwdata"},  m_pwdata,       32'd0);
    chk({tag, "_busy"},    32'(busy),      32'd0);
    chk({tag, "_ack"},     32'(ack),       32'd0);
  endtask

  initial begin
    #1 chk_idle_outs("reset");
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;

    // Single request, channel 0
    clr(); req = 2'b01; req_load0 = 32'h0000_1000;
    repeat (10) cyc();
    chk("s1_nwr", wa.size(), 3);
    chk_wr("s1_w0", 0, 32'h8, 32'h2);
    chk_wr("s1_w1", 1, 32'h0, 32'h1000);
    chk_wr("s1_w2", 2, 32'h8, 32'h3);
    chk("s1_nack", acks.size(), 1);
    chk("s1_ack", (acks.size() > 0) ? 32'(acks[0]) : 32'd0, 32'd1);

    // Channel 1 addressing
    clr(); req = 2'b10; req_load1 = 32'hDEAD_BEEF;
    repeat (10) cyc();
    chk_wr("s2_w0", 0, 32'h1C, 32'h2);
    chk_wr("s2_w1", 1, 32'h14, 32'hDEAD_BEEF);
    chk_wr("s2_w2", 2, 32'h1C, 32'h3);
    chk("s2_ack", (acks.size() > 0) ? 32'(acks[0]) : 32'd0, 32'd2);

    // Contention, each bit dropped on its own ack; channel 0 wins after ch1 served
    clr(); req = 2'b11;
    repeat (18) cyc();
    chk("s3_nack", acks.size(), 2);
    chk("s3_first", (acks.size() > 0) ? 32'(acks[0]) : 32'd0, 32'd1);
    chk("s3_second", (acks.size() > 1) ? 32'(acks[1]) : 32'd0, 32'd2);
    chk("s3_gap", (ackt.size() > 1) ? ackt[1] - ackt[0] : 0, 8);

    // Fairness: both held for four sequences
    clr(); auto_drop = 1'b0; req = 2'b11;
    repeat (32) cyc();
    req = 2'b00; auto_drop = 1'b1;
    repeat (10) cyc();
    chk("s4_nack", acks.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("s4_order", (i < acks.size()) ? 32'(acks[i]) : 32'd0, (i % 2 == 0) ? 32'd1 : 32'd2);
    for (int i = 1; i < 4; i++)
      chk("s4_gap", (i < ackt.size()) ? ackt[i] - ackt[i-1] : 0, 8);

    // Load change after grant is ignored
    clr(); req = 2'b01; req_load0 = 32'd5;
    repeat (3) cyc();
    req_load0 = 32'd9;
    repeat (7) cyc();
    chk_wr("s5_ld", 1, 32'h0, 32'd5);

    // Reset during LD_A
    clr(); req = 2'b01; req_load0 = 32'h77;
    repeat (4) cyc();
    #2 preset = 1'b1;
    #1 chk_idle_outs("s6_rst");
    @(posedge pclk); #1 preset = 1'b0;
    chk("s6_nwr", wa.size(), 1);
    chk("s6_noack", acks.size(), 0);
    repeat (10) cyc();
    chk_wr("s6_restart", 1, 32'h8, 32'h2);
    chk("s6_ack", (acks.size() > 0) ? 32'(acks[0]) : 32'd0, 32'd1);
    clr();
    #2 preset = 1'b1; req = 2'b11;
    @(posedge pclk); #1 preset = 1'b0;
    repeat (18) cyc();
    chk("s6_ch0_wins", (acks.size() > 0) ? 32'(acks[0]) : 32'd0, 32'd1);

    // Random traffic with occasional resets; the monitor checks every cycle
    for (int n = 0; n < 3000; n++) begin
      auto_drop = ($urandom_range(0, 1) == 1);
      cyc();
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      req_load0 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      req_load1 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #2 preset = 1'b1;
        #1 chk_idle_outs("rnd_rst");
        @(posedge pclk); #1 preset = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
